// File: rtl/smartlift_ctrl_if.sv
// Request/status bundle between the request decoder, the lift controller and the display logic.
// REQ_VALID is a one-cycle strobe with no ready: the controller accepts every strobe unconditionally.
interface smartlift_ctrl_if #(
    parameter int N_FLOORS = 9,
    parameter int FLOOR_W  = 4
);
    logic                REQ_VALID;
    logic [FLOOR_W-1:0]  REQ_FLOOR;
    logic [FLOOR_W-1:0]  CUR_FLOOR;
    logic [1:0]          MOVIMENTO;
    logic                DOOR_OPEN;
    logic                DOOR_CLOSED;
    logic [N_FLOORS-1:0] PENDING;
    logic                ARRIVE;
    logic                REQ_ERR;
    logic [1:0]          dbg_state;

    modport master (
        output REQ_VALID, REQ_FLOOR,
        input  CUR_FLOOR, MOVIMENTO, DOOR_OPEN, DOOR_CLOSED, PENDING, ARRIVE, REQ_ERR, dbg_state
    );

    modport slave (
        input  REQ_VALID, REQ_FLOOR,
        output CUR_FLOOR, MOVIMENTO, DOOR_OPEN, DOOR_CLOSED, PENDING, ARRIVE, REQ_ERR, dbg_state
    );
endinterface

// File: rtl/smartlift_ctrl.sv
// SCAN elevator controller: latches floor requests, travels floor by floor, dwells with the door open.
// Optional emergency stop input is enabled by defining SMARTLIFT_ESTOP_EN.
module smartlift_ctrl #(
    parameter int N_FLOORS      = 9,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 50_000_000,
    parameter int DOOR_CYCLES   = 100_000_000,
    parameter int HOME_FLOOR    = 0
) (
    input  logic CLOCK_50,
    input  logic RESET,
`ifdef SMARTLIFT_ESTOP_EN
    input  logic ESTOP,
`endif
    smartlift_ctrl_if.slave bus
);

    localparam int MAX_LOAD = ((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES) - 1;
    localparam int TIMER_W  = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD + 1);

    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] HOME        = FLOOR_W'(HOME_FLOOR);
    localparam logic [FLOOR_W:0]   FLOOR_LIM   = (FLOOR_W + 1)'(N_FLOORS);

    localparam logic [1:0] MOV_STOP = 2'd0;
    localparam logic [1:0] MOV_UP   = 2'd1;
    localparam logic [1:0] MOV_DOWN = 2'd2;
    localparam logic [1:0] MOV_HALT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MOVE = 2'd1,
        S_DOOR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic [1:0]          mov_q, mov_d;
    logic                door_open_q, door_open_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic                arrive_q, arrive_d;
    logic                req_err_q, req_err_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                dir_up_q, dir_up_d;

    logic                estop;
    logic                req_in_range;
    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] req_onehot;
    logic [N_FLOORS-1:0] cur_onehot;
    logic [N_FLOORS-1:0] next_onehot;
    logic [N_FLOORS-1:0] above_mask;
    logic [N_FLOORS-1:0] below_mask;
    logic                pend_here;
    logic                pend_above;
    logic                pend_below;

`ifdef SMARTLIFT_ESTOP_EN
    assign estop = ESTOP;
`else
    assign estop = 1'b0;
`endif

    assign req_in_range = ({1'b0, bus.REQ_FLOOR} < FLOOR_LIM);
    // Only used on a timer expiry in MOVE, where the direction always points at a pending floor.
    assign next_floor   = dir_up_q ? (cur_floor_q + FLOOR_W'(1)) : (cur_floor_q - FLOOR_W'(1));

    always_comb begin
        req_onehot  = '0;
        cur_onehot  = '0;
        next_onehot = '0;
        above_mask  = '0;
        below_mask  = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            req_onehot[i]  = bus.REQ_VALID && req_in_range && (bus.REQ_FLOOR == FLOOR_W'(i));
            cur_onehot[i]  = (cur_floor_q == FLOOR_W'(i));
            next_onehot[i] = (next_floor == FLOOR_W'(i));
            above_mask[i]  = (FLOOR_W'(i) > cur_floor_q);
            below_mask[i]  = (FLOOR_W'(i) < cur_floor_q);
        end
    end

    assign pend_here  = |(pending_q & cur_onehot);
    assign pend_above = |(pending_q & above_mask);
    assign pend_below = |(pending_q & below_mask);

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        door_open_d = door_open_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        arrive_d    = 1'b0;
        req_err_d   = bus.REQ_VALID && !req_in_range;
        pending_d   = pending_q | req_onehot;

        if (estop) begin
            // Frozen: only request latching continues; a door-floor request is still absorbed.
            if (state_q == S_DOOR) begin
                pending_d = pending_q | (req_onehot & ~cur_onehot);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_here) begin
                        state_d     = S_DOOR;
                        door_open_d = 1'b1;
                        timer_d     = DOOR_LOAD;
                        pending_d   = (pending_q | req_onehot) & ~cur_onehot;
                    end else if (pend_above && (dir_up_q || !pend_below)) begin
                        state_d  = S_MOVE;
                        dir_up_d = 1'b1;
                        timer_d  = TRAVEL_LOAD;
                    end else if (pend_below) begin
                        state_d  = S_MOVE;
                        dir_up_d = 1'b0;
                        timer_d  = TRAVEL_LOAD;
                    end
                end
                S_MOVE: begin
                    if (timer_q == '0) begin
                        cur_floor_d = next_floor;
                        arrive_d    = 1'b1;
                        // A request landing on the arrival edge is served by this stop.
                        if (|((pending_q | req_onehot) & next_onehot)) begin
                            state_d     = S_DOOR;
                            door_open_d = 1'b1;
                            timer_d     = DOOR_LOAD;
                            pending_d   = (pending_q | req_onehot) & ~next_onehot;
                        end else begin
                            timer_d = TRAVEL_LOAD;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                S_DOOR: begin
                    pending_d = pending_q | (req_onehot & ~cur_onehot);
                    if (|(req_onehot & cur_onehot)) begin
                        timer_d = DOOR_LOAD;
                    end else if (timer_q == '0) begin
                        state_d     = S_IDLE;
                        door_open_d = 1'b0;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    door_open_d = 1'b0;
                end
            endcase
        end

        // Derived from the next state so that releasing ESTOP restores the travel indication.
        if (estop) begin
            mov_d = MOV_HALT;
        end else if (state_d == S_MOVE) begin
            mov_d = dir_up_d ? MOV_UP : MOV_DOWN;
        end else begin
            mov_d = MOV_STOP;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cur_floor_q <= HOME;
            mov_q       <= MOV_STOP;
            door_open_q <= 1'b0;
            pending_q   <= '0;
            arrive_q    <= 1'b0;
            req_err_q   <= 1'b0;
            timer_q     <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            mov_q       <= mov_d;
            door_open_q <= door_open_d;
            pending_q   <= pending_d;
            arrive_q    <= arrive_d;
            req_err_q   <= req_err_d;
            timer_q     <= timer_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign bus.CUR_FLOOR   = cur_floor_q;
    assign bus.MOVIMENTO   = mov_q;
    assign bus.DOOR_OPEN   = door_open_q;
    assign bus.DOOR_CLOSED = ~door_open_q;
    assign bus.PENDING     = pending_q;
    assign bus.ARRIVE      = arrive_q;
    assign bus.REQ_ERR     = req_err_q;
    assign bus.dbg_state   = state_q;

endmodule
